// File: rtl/transpose_sequencer_if.sv
// Memory bus and transposition-responder handshake seen by transpose_sequencer.
interface transpose_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemData;
  logic [31:0]       WrData;
  logic              Enable;
  logic [2:0]        Operation;
  logic [31:0]       Column1;
  logic [31:0]       Column2;
  logic [31:0]       Column3;
  logic [31:0]       Column4;
  logic              Done;
  logic [31:0]       NewRow1;
  logic [31:0]       NewRow2;
  logic [31:0]       NewRow3;
  logic [31:0]       NewRow4;

  modport master (
    output MemRead, MemWrite, MemAddr, WrData, Enable, Operation,
           Column1, Column2, Column3, Column4,
    input  MemData, Done, NewRow1, NewRow2, NewRow3, NewRow4
  );

  modport slave (
    input  MemRead, MemWrite, MemAddr, WrData, Enable, Operation,
           Column1, Column2, Column3, Column4,
    output MemData, Done, NewRow1, NewRow2, NewRow3, NewRow4
  );
endinterface

// File: rtl/transpose_sequencer.sv
// Fetches a 4x4 matrix row by row, hands each row to the transposition unit and writes
// the column-ordered result back. Define TSEQ_TIMEOUT_EN to build the responder timeout.
module transpose_sequencer #(
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic                 Clock,
  input  logic                 ClearAll,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Finished,
  output logic                 Error,
  transpose_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;
  localparam logic [2:0] OP_TRANSPOSE = 3'b100;

  logic [2:0]        state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       col_q [4];
  logic [31:0]       tbuf_q [16];
  logic [31:0]       new_row [4];
  logic              busy_d, finished_d, mem_read_d, mem_write_d, enable_d;
  logic              mem_read_q, mem_write_q, enable_q;
  logic [2:0]        op_d, op_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       wr_data_d, wr_data_q;

`ifdef TSEQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] wait_q;
  logic            timeout_hit;
  assign timeout_hit = (wait_q == TO_W'(TIMEOUT - 1));
`endif

  assign new_row[0] = bus.NewRow1;
  assign new_row[1] = bus.NewRow2;
  assign new_row[2] = bus.NewRow3;
  assign new_row[3] = bus.NewRow4;

  // Next state, then every output computed for the cycle being entered so the ports stay registered.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (Start) begin
        state_d = S_READ;
        row_d   = '0;
        cnt_d   = '0;
      end
      S_READ: begin
        if (cnt_q == 4'd4) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.Done) begin
          cnt_d = '0;
          if (row_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
            row_d   = row_q + 2'd1;
          end
        end
`ifdef TSEQ_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_ERROR;
        end
`endif
      end
      S_WRITE: begin
        if (cnt_q == 4'd15) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_READ) || (state_d == S_ISSUE) ||
                  (state_d == S_WAIT) || (state_d == S_WRITE);
    finished_d  = (state_d == S_FINISH);
    mem_read_d  = (state_d == S_READ) && !cnt_d[2];
    mem_write_d = (state_d == S_WRITE);
    enable_d    = (state_d == S_ISSUE);
    op_d        = enable_d ? OP_TRANSPOSE : 3'b000;
    addr_d      = '0;
    wr_data_d   = '0;
    if (mem_read_d) begin
      addr_d = ADDR_W'(SRC_BASE) + ADDR_W'({row_d, cnt_d[1:0]});
    end
    if (mem_write_d) begin
      addr_d    = ADDR_W'(DST_BASE) + ADDR_W'(cnt_d);
      wr_data_d = tbuf_q[cnt_d];
    end
  end

  // Read data lands one cycle after its strobe, so READ slot c fills row register c-1.
  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      Busy        <= 1'b0;
      Finished    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      enable_q    <= 1'b0;
      op_q        <= 3'b000;
      addr_q      <= '0;
      wr_data_q   <= '0;
      for (int c = 0; c < 4; c++) col_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      Busy        <= busy_d;
      Finished    <= finished_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      enable_q    <= enable_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      if (state_q == S_READ && cnt_q != 4'd0) begin
        col_q[2'(cnt_q - 4'd1)] <= bus.MemData;
      end
    end
  end

  // Returned row r becomes column r of the buffer; contents need no reset.
  always_ff @(posedge Clock) begin
    if (!ClearAll && state_q == S_WAIT && bus.Done) begin
      for (int k = 0; k < 4; k++) tbuf_q[{2'(k), row_q}] <= new_row[k];
    end
  end

`ifdef TSEQ_TIMEOUT_EN
  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      wait_q <= '0;
      Error  <= 1'b0;
    end else begin
      wait_q <= (state_q == S_WAIT && state_d == S_WAIT) ? wait_q + TO_W'(1) : '0;
      if (state_q == S_IDLE && Start) begin
        Error <= 1'b0;
      end else if (state_d == S_ERROR) begin
        Error <= 1'b1;
      end
    end
  end
`else
  // Responder timeout not built; Error is constant 0.
  assign Error = 1'b0 & (TIMEOUT != 32'd0);
`endif

  assign bus.MemRead   = mem_read_q;
  assign bus.MemWrite  = mem_write_q;
  assign bus.MemAddr   = addr_q;
  assign bus.WrData    = wr_data_q;
  assign bus.Enable    = enable_q;
  assign bus.Operation = op_q;
  assign bus.Column1   = col_q[0];
  assign bus.Column2   = col_q[1];
  assign bus.Column3   = col_q[2];
  assign bus.Column4   = col_q[3];
endmodule

// File: tb/tb_transpose_sequencer.sv
// Bench for transpose_sequencer: memory model, echoing responder and a write-back scoreboard.
module tb_transpose_sequencer;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned SRC    = 0;
  localparam int unsigned DST    = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  logic Clock = 1'b0;
  logic ClearAll, Start;
  logic Busy, Finished, Error;

  transpose_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  transpose_sequencer #(
    .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(ADDR_W), .TIMEOUT(8)
  ) dut (
    .Clock(Clock), .ClearAll(ClearAll), .Start(Start),
    .Busy(Busy), .Finished(Finished), .Error(Error), .bus(bus)
  );

  always #5 Clock = ~Clock;

  logic [31:0] mem [256];
  wr_t         sb [$];
  int errors = 0, checks = 0;
  int cyc = 0, fin_cnt = 0, fin_cyc = 0, en_cnt = 0, wr_cnt = 0, last_en_cyc = -100;
  bit prev_en = 1'b0;
  bit resp_on = 1'b1;
  int stall_cfg = 0, stall_gen = 0, stray_req = 0;

  // Memory: a strobe seen in cycle k returns data in cycle k+1.
  logic              rd_pend = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  always @(negedge Clock) begin
    rd_pend = bus.MemRead;
    rd_addr = bus.MemAddr;
  end
  initial begin
    bus.MemData = '0;
    forever begin
      @(posedge Clock);
      #1;
      if (rd_pend) bus.MemData = mem[rd_addr];
    end
  end

  // Responder: echoes the issued row back, optionally stalled, plus stray Done on request.
  initial begin
    int stall_used, stray_ack;
    logic [31:0] r1, r2, r3, r4;
    stall_used = 0; stray_ack = 0;
    bus.Done = 1'b0;
    bus.NewRow1 = '0; bus.NewRow2 = '0; bus.NewRow3 = '0; bus.NewRow4 = '0;
    forever begin
      @(negedge Clock);
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        @(posedge Clock); #1;
        bus.Done = 1'b1;
        bus.NewRow1 = 32'h0BAD_0001; bus.NewRow2 = 32'h0BAD_0002;
        bus.NewRow3 = 32'h0BAD_0003; bus.NewRow4 = 32'h0BAD_0004;
        @(posedge Clock); #1;
        bus.Done = 1'b0;
      end else if (bus.Enable && resp_on) begin
        r1 = bus.Column1; r2 = bus.Column2; r3 = bus.Column3; r4 = bus.Column4;
        if (stall_gen != stall_used) begin
          stall_used = stall_gen;
          repeat (stall_cfg) @(posedge Clock);
        end
        @(posedge Clock); #1;
        bus.Done = 1'b1;
        bus.NewRow1 = r1; bus.NewRow2 = r2; bus.NewRow3 = r3; bus.NewRow4 = r4;
        @(posedge Clock); #1;
        bus.Done = 1'b0;
      end
    end
  end

  task automatic push_expected();
    wr_t e;
    for (int i = 0; i < 16; i++) begin
      e.a = ADDR_W'(DST + i);
      e.d = mem[ADDR_W'(SRC + 4 * (i % 4) + i / 4)];
      sb.push_back(e);
    end
  endtask

  // Scoreboard consumer and bus monitor, run once per cycle at the falling edge.
  task automatic observe();
    wr_t e;
    if (bus.MemWrite) begin
      mem[bus.MemAddr] = bus.WrData;
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_write: unexpected write addr=%0d data=%h in cycle %0d, required none",
                 bus.MemAddr, bus.WrData, cyc);
      end else begin
        e = sb.pop_front();
        if ({bus.MemAddr, bus.WrData} !== {e.a, e.d}) begin
          errors++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.MemAddr, bus.WrData, e.a, e.d);
        end
      end
    end
    if (bus.Enable) begin
      en_cnt++;
      checks++;
      if (bus.Operation !== 3'b100 || prev_en || (cyc - last_en_cyc) < 6) begin
        errors++;
        $display("FAIL enable_pulse: op=%b prev_en=%0d spacing=%0d, required op=100 prev_en=0 spacing>=6",
                 bus.Operation, prev_en, cyc - last_en_cyc);
      end
      last_en_cyc = cyc;
    end
    prev_en = bus.Enable;
    if (Finished === 1'b1) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    cyc++;
    observe();
  endtask

  // Start is sampled at edge 0; the first observed cycle is cycle 1.
  task automatic launch(input bit push);
    Start = 1'b1;
    last_en_cyc = -100;
    @(negedge Clock);
    Start = 1'b0;
    cyc = 1;
    if (push) push_expected();
    observe();
  endtask

  task automatic run_until_finish(input int max_cycles);
    int f0, n;
    f0 = fin_cnt; n = 0;
    while (fin_cnt == f0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (fin_cnt == f0) begin
      errors++;
      $display("FAIL finish_timeout: no Finished within %0d cycles, required one", max_cycles);
    end
  endtask

  task automatic load_counting();
    for (int i = 0; i < 16; i++) begin
      mem[ADDR_W'(SRC + i)] = 32'(i + 1);
      mem[ADDR_W'(DST + i)] = '0;
    end
  endtask

  task automatic check_counting_result(input string name);
    int unsigned exp_t [16];
    exp_t = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[ADDR_W'(DST + i)] !== 32'(exp_t[i])) begin
        errors++;
        $display("FAIL %s: mem[DST+%0d]=%0d, required %0d", name, i, mem[ADDR_W'(DST + i)], exp_t[i]);
      end
    end
  endtask

  task automatic test_reset();
    ClearAll = 1'b1;
    Start    = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({Busy, Finished, Error, bus.MemRead, bus.MemWrite, bus.Enable, bus.Operation} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/fin/err/rd/wr/en/op=%b, required 0",
               {Busy, Finished, Error, bus.MemRead, bus.MemWrite, bus.Enable, bus.Operation});
    end
    checks++;
    if ({bus.MemAddr, bus.WrData} !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wrdata=%h, required 0", bus.MemAddr, bus.WrData);
    end
    checks++;
    if ({bus.Column1, bus.Column2, bus.Column3, bus.Column4} !== 128'd0) begin
      errors++;
      $display("FAIL reset_columns: %h %h %h %h, required 0",
               bus.Column1, bus.Column2, bus.Column3, bus.Column4);
    end
    ClearAll = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int e0;
    load_counting();
    e0 = en_cnt;
    launch(1'b1);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_c1: Busy=%b, required 1", Busy);
    end
    run_until_finish(100);
    checks++;
    if (fin_cyc !== 45 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_finish: cycle=%0d Busy=%b, required cycle 45 Busy 0", fin_cyc, Busy);
    end
    checks++;
    if (en_cnt - e0 !== 4 || sb.size() !== 0) begin
      errors++;
      $display("FAIL basic_counts: enables=%0d pending_writes=%0d, required 4 and 0",
               en_cnt - e0, sb.size());
    end
    check_counting_result("basic_mem");
    repeat (2) tick();
  endtask

  task automatic test_passthrough();
    logic [31:0] v [4];
    v = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 16; i++) mem[ADDR_W'(SRC + i)] = $urandom;
    for (int c = 0; c < 4; c++) mem[ADDR_W'(SRC + c)] = v[c];
    launch(1'b1);
    run_until_finish(100);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (mem[ADDR_W'(DST + 4 * c)] !== v[c]) begin
        errors++;
        $display("FAIL passthrough: mem[DST+%0d]=%h, required %h", 4 * c, mem[ADDR_W'(DST + 4 * c)], v[c]);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_busy_start();
    int f0, e0, n;
    load_counting();
    f0 = fin_cnt; e0 = en_cnt; n = 0;
    launch(1'b1);
    stray_req++;
    while (fin_cnt == f0 && n < 100) begin
      tick();
      n++;
      Start = (cyc == 3) || (cyc == 20);
    end
    Start = 1'b0;
    repeat (10) tick();
    checks++;
    if (fin_cnt - f0 !== 1 || fin_cyc !== 45) begin
      errors++;
      $display("FAIL busy_start_finish: pulses=%0d last_cycle=%0d, required 1 pulse in cycle 45",
               fin_cnt - f0, fin_cyc);
    end
    checks++;
    if (en_cnt - e0 !== 4 || sb.size() !== 0) begin
      errors++;
      $display("FAIL busy_start_counts: enables=%0d pending_writes=%0d, required 4 and 0",
               en_cnt - e0, sb.size());
    end
    check_counting_result("busy_start_mem");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 16; i++) begin
      mem[ADDR_W'(SRC + i)] = $urandom;
      mem[ADDR_W'(DST + i)] = 32'hDEAD_0000 + 32'(i);
    end
    launch(1'b1);
    while (cyc < 34) tick();
    ClearAll = 1'b1;
    tick();
    ClearAll = 1'b0;
    checks++;
    if ({Busy, Finished, bus.MemRead, bus.MemWrite, bus.Enable, bus.Operation} !== 8'd0 ||
        {bus.MemAddr, bus.WrData} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy/fin/rd/wr/en/op=%b addr=%h wrdata=%h, required 0",
               {Busy, Finished, bus.MemRead, bus.MemWrite, bus.Enable, bus.Operation},
               bus.MemAddr, bus.WrData);
    end
    checks++;
    if (sb.size() !== 10) begin
      errors++;
      $display("FAIL mid_reset_writes: pending=%0d, required 10 unwritten", sb.size());
    end
    sb.delete();
    for (int i = 6; i < 16; i++) begin
      checks++;
      if (mem[ADDR_W'(DST + i)] !== 32'hDEAD_0000 + 32'(i)) begin
        errors++;
        $display("FAIL mid_reset_untouched: mem[DST+%0d]=%h, required %h",
                 i, mem[ADDR_W'(DST + i)], 32'hDEAD_0000 + 32'(i));
      end
    end
    repeat (2) tick();
    launch(1'b1);
    run_until_finish(100);
    checks++;
    if (fin_cyc !== 45 || sb.size() !== 0) begin
      errors++;
      $display("FAIL mid_reset_rerun: cycle=%0d pending=%0d, required 45 and 0", fin_cyc, sb.size());
    end
    repeat (2) tick();
  endtask

`ifdef TSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int w0;
    resp_on = 1'b0;
    w0 = wr_cnt;
    launch(1'b0);
    while (cyc < 14) tick();
    checks++;
    if (Error !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: Error=%b Busy=%b in cycle 14, required 0 and 1", Error, Busy);
    end
    tick();
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_error: Error=%b Busy=%b in cycle 15, required 1 and 0", Error, Busy);
    end
    repeat (10) tick();
    checks++;
    if (Error !== 1'b1 || wr_cnt !== w0) begin
      errors++;
      $display("FAIL timeout_sticky: Error=%b writes=%0d, required 1 and 0", Error, wr_cnt - w0);
    end
    resp_on = 1'b1;
    load_counting();
    launch(1'b1);
    checks++;
    if (Error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: Error=%b after Start, required 0", Error);
    end
    run_until_finish(100);
    checks++;
    if (fin_cyc !== 45 || sb.size() !== 0) begin
      errors++;
      $display("FAIL timeout_rerun: cycle=%0d pending=%0d, required 45 and 0", fin_cyc, sb.size());
    end
  endtask
`else
  task automatic test_stall();
    load_counting();
    stall_cfg = 50;
    stall_gen++;
    launch(1'b1);
    while (cyc < 30) tick();
    checks++;
    if (Busy !== 1'b1 || Error !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait: Busy=%b Error=%b in cycle 30, required 1 and 0", Busy, Error);
    end
    run_until_finish(200);
    checks++;
    if (fin_cyc !== 95 || Error !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL stall_finish: cycle=%0d Error=%b pending=%0d, required 95, 0, 0",
               fin_cyc, Error, sb.size());
    end
    check_counting_result("stall_mem");
  endtask
`endif

  initial begin
    ClearAll = 1'b1;
    Start    = 1'b0;
    test_reset();
    test_basic();
    test_passthrough();
    test_busy_start();
    test_mid_reset();
`ifdef TSEQ_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
